// File: rtl/alarm_bus_pkg.sv
// Shared definitions for the alarm bus arbiter: FSM state encoding and index-width helpers.
package alarm_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GUARD   = 2'd1,
        ST_DRIVE   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection starting after the last served source.
// ALARM_PRIO_EN: source 0 overrides the rotation whenever it requests.
module rr_picker
    import alarm_bus_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int IW   = idx_width(NSRC)
) (
    input  logic [NSRC-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   winner,
    output logic            found
);

    logic [IW-1:0] pos;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        for (int k = 1; k <= NSRC; k++) begin
            pos = IW'((int'(last) + k) % NSRC);
            if (!found && req[pos]) begin
                found  = 1'b1;
                winner = pos;
            end
        end
`ifdef ALARM_PRIO_EN
        if (req[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
    end

endmodule

// File: rtl/alarm_bus_arbiter.sv
// Single-driver arbiter for the shared alarm bus with turnaround guard slots and ack timeout.
// ALARM_PRIO_EN: source 0 has fixed top priority and does not move the round-robin pointer.
module alarm_bus_arbiter
    import alarm_bus_pkg::*;
#(
    parameter int N       = 8,
    parameter int NSRC    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSRC-1:0]   req,
    input  logic [NSRC*N-1:0] src_data,
    input  logic              bus_ack,
    output logic [N-1:0]      buf_data,
    output logic              buf_en,
    output logic [NSRC-1:0]   grant,
    output logic              bus_valid,
    output logic [NSRC-1:0]   src_done,
    output logic              timeout_err
);

    localparam int IW = idx_width(NSRC);
    localparam int CW = idx_width(TIMEOUT);
    localparam logic [NSRC-1:0] ONE_HOT0 = NSRC'(1);

    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] last;
    logic [CW-1:0] cnt;
    logic [IW-1:0] winner;
    logic          found;
    logic [N-1:0]  win_data;

    rr_picker #(.NSRC(NSRC), .IW(IW)) u_picker (
        .req    (req),
        .last   (last),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NSRC; i++)
            if (winner == IW'(i)) win_data = src_data[i*N +: N];
    end

    // NOTE: state and outputs update with <= so every branch sees the pre-edge values.
    // Async reset drops buf_en at once, releasing the bus mid-transfer without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            last        <= IW'(NSRC - 1);
            cnt         <= '0;
            buf_data    <= '0;
            buf_en      <= 1'b0;
            grant       <= '0;
            bus_valid   <= 1'b0;
            src_done    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        idx      <= winner;
                        buf_data <= win_data;
                        state    <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    cnt       <= '0;
                    buf_en    <= 1'b1;
                    bus_valid <= 1'b1;
                    grant     <= ONE_HOT0 << idx;
                    state     <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    // Ack wins over the terminal count when both land together.
                    if (bus_ack || cnt == CW'(TIMEOUT - 1)) begin
                        buf_en    <= 1'b0;
                        bus_valid <= 1'b0;
                        grant     <= '0;
                        if (bus_ack) src_done    <= ONE_HOT0 << idx;
                        else         timeout_err <= 1'b1;
                        state <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    src_done    <= '0;
                    timeout_err <= 1'b0;
`ifdef ALARM_PRIO_EN
                    if (idx != '0) last <= idx;
`else
                    last <= idx;
`endif
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
